// File: rtl/square_sample_synth.sv
// Square-wave PCM sample generator for the AC97 playback path.
// Emits one signed 20-bit sample per sample period into the write side of the
// AC97 sample FIFO, with programmable half-period (in samples) and amplitude.
// A one-entry pending stage absorbs FIFO backpressure; samples that arrive while
// it is occupied are dropped and counted in a saturating overrun counter.
module square_sample_synth #(
    parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
    parameter int unsigned SAMPLE_RATE    = 48_000,
    // Clock cycles per sample period; must be at least 4 so that the registered
    // write strobe leaves the FIFO full flag time to take effect.
    parameter int unsigned TICK_DIV       = CPU_CLOCK_FREQ / SAMPLE_RATE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] half_period,
    input  logic [18:0] amplitude,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [19:0] fifo_din,
    output logic [7:0]  overrun_count
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    // Sample-period divider.
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    // Waveform position within the current half-wave and its sign.
    logic [15:0] phase_q, phase_d;
    logic        polarity_q, polarity_d;
    logic [19:0] sample;

    // One-entry holding stage between the generator and the FIFO.
    logic        pend_valid_q, pend_valid_d;
    logic [19:0] pend_data_q, pend_data_d;
    logic        issue;

    // Registered FIFO-facing outputs and the overrun counter.
    logic        wr_en_q, wr_en_d;
    logic [19:0] din_q, din_d;
    logic [7:0]  overrun_q, overrun_d;

    assign tick  = enable && (tick_cnt_q == TickLast);
    assign issue = pend_valid_q && !fifo_full;

    // Tick divider: counts while enabled, wraps on the tick, parks at 0 when disabled.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!enable) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end
    end

    // Sample value for the current tick, taken from polarity before it advances.
    always_comb begin
        sample = '0;
        if (half_period != 16'd0) begin
            if (polarity_q) begin
                sample = ~{1'b0, amplitude} + 20'd1;
            end else begin
                sample = {1'b0, amplitude};
            end
        end
    end

    // Phase/polarity advance; the >= compare lets a shrunk half_period wrap at once.
    always_comb begin
        phase_d    = phase_q;
        polarity_d = polarity_q;
        if (!enable) begin
            phase_d    = '0;
            polarity_d = 1'b0;
        end else if (tick) begin
            if (half_period == 16'd0) begin
                phase_d = '0;
            end else if (phase_q >= half_period - 16'd1) begin
                phase_d    = '0;
                polarity_d = ~polarity_q;
            end else begin
                phase_d = phase_q + 16'd1;
            end
        end
    end

    // Pending stage: issue frees the slot, a tick fills an empty slot or counts a drop.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        overrun_d    = overrun_q;
        if (issue) begin
            pend_valid_d = 1'b0;
        end
        if (tick) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_data_d  = sample;
            end else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
    end

    // FIFO write decision; the data register holds its value between strobes.
    always_comb begin
        wr_en_d = issue;
        din_d   = din_q;
        if (issue) begin
            din_d = pend_data_q;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            phase_q      <= '0;
            polarity_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            overrun_q    <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            phase_q      <= phase_d;
            polarity_q   <= polarity_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fifo_wr_en    = wr_en_q;
    assign fifo_din      = din_q;
    assign overrun_count = overrun_q;

endmodule
